// File: rtl/memory_arbiter.sv
// memory_arbiter: registered round-robin arbiter of NUM_CH requester channels onto one memory port.
// Define MEMORY_ARBITER_LOCK_EN to let a channel keep the grant across transactions via lock_i.
`ifndef MEMORY_ADDR_WIDTH
`define MEMORY_ADDR_WIDTH 16
`endif
`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 32
`endif

module memory_arbiter #(
  parameter int unsigned NUM_CH      = 6,
  parameter int unsigned ADDR_W      = `MEMORY_ADDR_WIDTH,
  parameter int unsigned DATA_W      = `MEMORY_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         execute_i,
  input  logic [NUM_CH-1:0]         lock_i,
  input  logic [2*NUM_CH-1:0]       mem_func_i,
  input  logic [ADDR_W*NUM_CH-1:0]  address1_i,
  input  logic [ADDR_W*NUM_CH-1:0]  address2_i,
  input  logic [DATA_W*NUM_CH-1:0]  write_data_i,
  output logic [NUM_CH-1:0]         ack_o,
  output logic                      err_o,
  output logic [DATA_W-1:0]         read_data_o,
  output logic [$clog2(NUM_CH)-1:0] grant_o,
  output logic                      busy_o,
  output logic [1:0]                mem_func_o,
  output logic                      execute_o,
  output logic [ADDR_W-1:0]         address1_o,
  output logic [ADDR_W-1:0]         address2_o,
  output logic [DATA_W-1:0]         write_data_o,
  input  logic                      mem_ready_i,
  input  logic [DATA_W-1:0]         mem_read_data_i
);
  localparam int unsigned GW = $clog2(NUM_CH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  state_t r_state, w_next;

  logic [GW-1:0]       r_grant, r_rr, w_pick, w_grant_inc, w_rr_nxt;
  logic [NUM_CH-1:0]   w_cand, w_grant_oh, w_ack_nxt, r_ack;
  logic [2*NUM_CH-1:0] w_dbl;
  logic                w_found, w_ready_hit, w_timeout, w_done;
  logic [15:0]         r_cnt;
  logic                r_exec, r_err, r_busy, w_exec_nxt;
  logic [DATA_W-1:0]   r_rdata, w_rdata_nxt, r_wdata, w_wdata_sel;
  logic [1:0]          r_func, w_func_sel;
  logic [ADDR_W-1:0]   r_addr1, r_addr2, w_addr1_sel, w_addr2_sel;

  assign w_grant_oh  = NUM_CH'(1) << r_grant;
  assign w_grant_inc = (r_grant == GW'(NUM_CH - 1)) ? '0 : r_grant + GW'(1);

`ifdef MEMORY_ARBITER_LOCK_EN
  logic r_locked, w_lock_cur;
  assign w_lock_cur = |(lock_i & w_grant_oh);
  assign w_cand     = (r_locked && w_lock_cur) ? (execute_i & w_grant_oh) : execute_i;
  assign w_rr_nxt   = w_lock_cur ? r_grant : w_grant_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_locked <= 1'b0;
    else if (w_done)                           r_locked <= w_lock_cur;
    else if (r_state == S_IDLE && !w_lock_cur) r_locked <= 1'b0;
  end
`else
  logic w_unused_lock;
  assign w_unused_lock = ^lock_i;
  assign w_cand        = execute_i;
  assign w_rr_nxt      = w_grant_inc;
`endif

  // Rotate requests so bit 0 corresponds to rr_ptr; first set bit wins, then map back modulo NUM_CH.
  assign w_dbl = {w_cand, w_cand} >> r_rr;

  always_comb begin
    logic [GW:0] v_sum;
    v_sum   = '0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      v_sum = {1'b0, r_rr} + (GW+1)'(i);
      if (!w_found && w_dbl[i]) begin
        w_found = 1'b1;
        w_pick  = (v_sum >= (GW+1)'(NUM_CH)) ? GW'(v_sum - (GW+1)'(NUM_CH)) : GW'(v_sum);
      end
    end
  end

  assign w_func_sel  = 2'(mem_func_i >> (32'(w_pick) * 2));
  assign w_addr1_sel = ADDR_W'(address1_i >> (32'(w_pick) * ADDR_W));
  assign w_addr2_sel = ADDR_W'(address2_i >> (32'(w_pick) * ADDR_W));
  assign w_wdata_sel = DATA_W'(write_data_i >> (32'(w_pick) * DATA_W));

  assign w_ready_hit = (r_state == S_WAIT) && mem_ready_i;
  assign w_timeout   = (r_state == S_WAIT) && !mem_ready_i && (r_cnt == 16'(TIMEOUT_CYC - 1));
  assign w_done      = w_ready_hit || w_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (w_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_exec_nxt  = (r_state == S_ISSUE);
    w_ack_nxt   = '0;
    w_rdata_nxt = '0;
    if (w_done)      w_ack_nxt   = w_grant_oh;
    if (w_ready_hit) w_rdata_nxt = mem_read_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant <= '0;
      r_rr    <= '0;
      r_cnt   <= '0;
      r_exec  <= 1'b0;
      r_ack   <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_busy  <= 1'b0;
      r_func  <= '0;
      r_addr1 <= '0;
      r_addr2 <= '0;
      r_wdata <= '0;
    end else begin
      r_exec  <= w_exec_nxt;
      r_ack   <= w_ack_nxt;
      r_err   <= w_timeout;
      r_rdata <= w_rdata_nxt;
      r_busy  <= (w_next != S_IDLE);
      if (r_state == S_IDLE && w_found) begin
        r_grant <= w_pick;
        r_func  <= w_func_sel;
        r_addr1 <= w_addr1_sel;
        r_addr2 <= w_addr2_sel;
        r_wdata <= w_wdata_sel;
      end
      if (r_state == S_ISSUE)     r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + 16'd1;
      if (w_done) r_rr <= w_rr_nxt;
    end
  end

  assign ack_o        = r_ack;
  assign err_o        = r_err;
  assign read_data_o  = r_rdata;
  assign grant_o      = r_grant;
  assign busy_o       = r_busy;
  assign execute_o    = r_exec;
  assign mem_func_o   = r_func;
  assign address1_o   = r_addr1;
  assign address2_o   = r_addr2;
  assign write_data_o = r_wdata;

endmodule

// File: tb/tb_memory_arbiter.sv
// Testbench for memory_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized requesters and memory.
module tb_memory_arbiter;
  localparam int NCH = 6;
  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int TO  = 8;

  logic                clk;
  logic                rst_n;
  logic [NCH-1:0]      execute_i, lock_i;
  logic [2*NCH-1:0]    mem_func_i;
  logic [AW*NCH-1:0]   address1_i, address2_i;
  logic [DW*NCH-1:0]   write_data_i;
  logic [NCH-1:0]      ack_o;
  logic                err_o, busy_o, execute_o, mem_ready_i;
  logic [DW-1:0]       read_data_o, write_data_o, mem_read_data_i;
  logic [2:0]          grant_o;
  logic [1:0]          mem_func_o;
  logic [AW-1:0]       address1_o, address2_o;

  int total = 0;
  int bad   = 0;

  memory_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .execute_i(execute_i), .lock_i(lock_i),
    .mem_func_i(mem_func_i), .address1_i(address1_i), .address2_i(address2_i),
    .write_data_i(write_data_i), .ack_o(ack_o), .err_o(err_o), .read_data_o(read_data_o),
    .grant_o(grant_o), .busy_o(busy_o), .mem_func_o(mem_func_o), .execute_o(execute_o),
    .address1_o(address1_o), .address2_o(address2_o), .write_data_o(write_data_o),
    .mem_ready_i(mem_ready_i), .mem_read_data_i(mem_read_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit bitat(input logic [NCH-1:0] v, input int i);
    logic [NCH-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  task automatic set_ch(input int c, input logic [1:0] f, input logic [AW-1:0] a1,
                        input logic [AW-1:0] a2, input logic [DW-1:0] wd);
    mem_func_i   = (mem_func_i & ~((2*NCH)'(2'b11) << (2*c))) | ((2*NCH)'(f) << (2*c));
    address1_i   = (address1_i & ~((AW*NCH)'({AW{1'b1}}) << (AW*c))) | ((AW*NCH)'(a1) << (AW*c));
    address2_i   = (address2_i & ~((AW*NCH)'({AW{1'b1}}) << (AW*c))) | ((AW*NCH)'(a2) << (AW*c));
    write_data_i = (write_data_i & ~((DW*NCH)'({DW{1'b1}}) << (DW*c))) | ((DW*NCH)'(wd) << (DW*c));
  endtask

  // Reference model: a transaction occupies the grant edge, one issue cycle, then waits
  // for memory ready or TO wait cycles; the idle turnaround is the cycle after the ack.
  bit             m_active, m_locked;
  int             m_age, m_rr, m_grant;
  logic [NCH-1:0] e_ack;
  logic           e_err, e_exec, e_busy;
  logic [DW-1:0]  e_rd, e_wd;
  logic [2:0]     e_grant;
  logic [1:0]     e_func;
  logic [AW-1:0]  e_a1, e_a2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_locked = 0; m_age = 0; m_rr = 0; m_grant = 0;
      e_ack = '0; e_err = 0; e_exec = 0; e_busy = 0; e_rd = '0; e_wd = '0;
      e_grant = '0; e_func = '0; e_a1 = '0; e_a2 = '0;
    end else begin
      logic [NCH-1:0] cand;
      int c;
      e_exec = 0; e_ack = '0; e_err = 0; e_rd = '0;
      if (!m_active) begin
        cand = execute_i;
`ifdef MEMORY_ARBITER_LOCK_EN
        if (m_locked && bitat(lock_i, m_grant)) cand = execute_i & (NCH'(1) << m_grant);
        else m_locked = 0;
`endif
        for (int k = 0; k < NCH; k++) begin
          c = (m_rr + k) % NCH;
          if (!m_active && bitat(cand, c)) begin
            m_active = 1; m_age = 0; m_grant = c;
            e_grant = 3'(c);
            e_func  = 2'(mem_func_i >> (2*c));
            e_a1    = AW'(address1_i >> (AW*c));
            e_a2    = AW'(address2_i >> (AW*c));
            e_wd    = DW'(write_data_i >> (DW*c));
          end
        end
      end else begin
        m_age++;
        if (m_age == 1) e_exec = 1;
        else if (mem_ready_i || (m_age - 1 >= TO)) begin
          e_ack    = NCH'(1) << m_grant;
          e_err    = !mem_ready_i;
          e_rd     = mem_ready_i ? mem_read_data_i : '0;
          m_active = 0;
`ifdef MEMORY_ARBITER_LOCK_EN
          m_locked = bitat(lock_i, m_grant);
          m_rr     = m_locked ? m_grant : (m_grant + 1) % NCH;
`else
          m_rr     = (m_grant + 1) % NCH;
`endif
        end
      end
      e_busy = m_active;
    end
  end

  always @(posedge clk) begin
    #1;
    chk("ack", 64'(ack_o), 64'(e_ack));
    chk("err", 64'(err_o), 64'(e_err));
    chk("rdata", 64'(read_data_o), 64'(e_rd));
    chk("grant", 64'(grant_o), 64'(e_grant));
    chk("busy", 64'(busy_o), 64'(e_busy));
    chk("exec", 64'(execute_o), 64'(e_exec));
    chk("func", 64'(mem_func_o), 64'(e_func));
    chk("addr1", 64'(address1_o), 64'(e_a1));
    chk("addr2", 64'(address2_o), 64'(e_a2));
    chk("wdata", 64'(write_data_o), 64'(e_wd));
  end

  // Memory: mode 0 fixed latency after execute, 1 random ready, 2 never ready, 3 driven by main.
  int          mem_mode = 0;
  int          mem_lat  = 1;
  int          cd = 0;
  logic [DW-1:0] mem_fixed = 32'hCAFE_0002;
  always @(negedge clk) begin
    if (!rst_n || mem_mode != 0) cd = 0;
    if (mem_mode != 3) begin
      mem_ready_i     = 0;
      mem_read_data_i = $urandom;
      case (mem_mode)
        0: begin
          if (cd > 0) begin
            cd--;
            if (cd == 0) begin mem_ready_i = 1; mem_read_data_i = mem_fixed; end
          end
          if (execute_o) cd = mem_lat;
        end
        1: mem_ready_i = ($urandom_range(0, 2) == 0);
        default: mem_ready_i = 0;
      endcase
    end
  end

  bit auto_req = 0;
  always @(negedge clk) begin
    if (auto_req) begin
      logic [NCH-1:0] nr;
      nr = execute_i & ~ack_o;
      for (int c = 0; c < NCH; c++) begin
        if (!bitat(execute_i, c)) begin
          set_ch(c, 2'($urandom), 16'($urandom), 16'($urandom), $urandom);
          if ($urandom_range(0, 3) == 0) nr = nr | (NCH'(1) << c);
        end
      end
      execute_i = nr;
      if ($urandom_range(0, 7) == 0) lock_i = NCH'($urandom);
    end
  end

  int ack_cnt = 0;
  int err_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (ack_o != 0) ack_cnt++;
    if (err_o) err_cnt++;
  end

  task automatic wait_ack(output int n, output logic [NCH-1:0] a);
    n = 0; a = '0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1; n++;
      if (ack_o != 0) begin a = ack_o; return; end
    end
    chk("ack_wait_expired", 64'(0), 64'(1));
  endtask

  function automatic int oh_idx(input logic [NCH-1:0] v);
    for (int i = 0; i < NCH; i++) if (bitat(v, i)) return i;
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; execute_i = '0; lock_i = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int n, n_exec, a1_seen, f_seen, ac0, ac1;
    logic [NCH-1:0] a;
    int seq[$];
    int exp_rr[7] = '{0, 1, 2, 3, 4, 5, 0};
`ifdef MEMORY_ARBITER_LOCK_EN
    int exp_lk[6] = '{1, 3, 3, 3, 3, 1};
`else
    int exp_lk[6] = '{1, 3, 1, 3, 1, 3};
`endif
    rst_n = 0; execute_i = '0; lock_i = '0; mem_func_i = '0; address1_i = '0;
    address2_i = '0; write_data_i = '0; mem_ready_i = 0; mem_read_data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {2'b0, ack_o, err_o, busy_o, execute_o, grant_o, address1_o, mem_func_o, read_data_o}, 64'd0);
    @(negedge clk); rst_n = 1;

    // Single request on channel 2, memory ready two cycles after execute.
    mem_mode = 0; mem_lat = 2;
    @(negedge clk);
    set_ch(2, 2'b01, 16'h0010, 16'h0022, 32'hA5A5_0001);
    execute_i = 6'b000100;
    n = 0; n_exec = 0; a1_seen = 0; f_seen = 0; a = '0;
    for (int i = 0; i < 20 && a == 0; i++) begin
      @(posedge clk); #1; n++;
      if (execute_o) begin n_exec = n; a1_seen = int'(address1_o); f_seen = int'(mem_func_o); end
      if (ack_o != 0) a = ack_o;
    end
    execute_i = '0;
    chk("t1_exec_cycle", 64'(n_exec), 64'd2);
    chk("t1_addr1", 64'(a1_seen), 64'h10);
    chk("t1_func", 64'(f_seen), 64'd1);
    chk("t1_ack_cycle", 64'(n), 64'd5);
    chk("t1_ack", 64'(a), 64'b000100);
    chk("t1_rdata", 64'(read_data_o), 64'hCAFE_0002);
    chk("t1_err", 64'(err_o), 64'd0);

    // All channels requesting continuously from a fresh reset.
    do_reset();
    mem_lat = 1;
    for (int c = 0; c < NCH; c++) set_ch(c, 2'(c), 16'(16'h100 + c), 16'(16'h200 + c), 32'(32'h300 + c));
    execute_i = '1;
    for (int k = 0; k < 7; k++) begin
      wait_ack(n, a);
      seq.push_back(oh_idx(a));
      if (k == 0) ac0 = n;
      if (k == 1) ac1 = n;
    end
    execute_i = '0;
    for (int k = 0; k < 7; k++) chk("rr_order", 64'(seq[k]), 64'(exp_rr[k]));
    chk("rr_first_latency", 64'(ac0), 64'd4);
    chk("rr_spacing", 64'(ac1), 64'd4);

    // Memory never ready: timeout after TO wait cycles, then normal service resumes.
    repeat (3) @(negedge clk);
    mem_mode = 2;
    set_ch(5, 2'b10, 16'h0055, 16'h0066, 32'h7777_0005);
    execute_i = 6'b100000;
    wait_ack(n, a);
    execute_i = '0;
    chk("to_cycle", 64'(n), 64'd10);
    chk("to_ack", 64'(a), 64'b100000);
    chk("to_err", 64'(err_o), 64'd1);
    chk("to_rdata", 64'(read_data_o), 64'd0);
    mem_mode = 0; mem_lat = 1;
    @(negedge clk);
    execute_i = 6'b000010;
    wait_ack(n, a);
    execute_i = '0;
    chk("after_to_ack", 64'(a), 64'b000010);
    chk("after_to_err", 64'(err_o), 64'd0);

    // Asynchronous reset while waiting; stale ready after release must be ignored.
    repeat (2) @(negedge clk);
    mem_mode = 3; mem_ready_i = 0;
    set_ch(4, 2'b11, 16'h0404, 16'h0505, 32'h0606_0606);
    execute_i = 6'b010000;
    repeat (3) @(posedge clk);
    #3; rst_n = 0; #1;
    chk("async_reset_outputs", {2'b0, ack_o, err_o, busy_o, execute_o, grant_o, address1_o, mem_func_o, read_data_o}, 64'd0);
    @(negedge clk); execute_i = '0;
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    set_ch(0, 2'b01, 16'h0A0A, 16'h0B0B, 32'h0C0C_0C0C);
    execute_i = 6'b000001; mem_ready_i = 1;
    @(posedge clk); #1;
    chk("rst_grant", 64'(grant_o), 64'd0);
    @(negedge clk); mem_ready_i = 1;
    @(posedge clk); #1;
    chk("stale_ready_ignored", 64'(ack_o), 64'd0);
    @(negedge clk); mem_ready_i = 0;
    @(posedge clk); #1;
    @(negedge clk); mem_ready_i = 1; mem_read_data_i = 32'h1234_5678;
    @(posedge clk); #1;
    chk("rst_ack", 64'(ack_o), 64'b000001);
    chk("rst_rdata", 64'(read_data_o), 64'h1234_5678);
    @(negedge clk); mem_ready_i = 0; execute_i = '0;

    // Channel 3 holds lock_i while channels 1 and 3 both request.
    mem_mode = 0;
    do_reset();
    mem_lat = 1;
    lock_i = 6'b001000;
    execute_i = 6'b001010;
    seq.delete();
    for (int k = 0; k < 6; k++) begin
      wait_ack(n, a);
      seq.push_back(oh_idx(a));
      if (k == 3) lock_i = '0;
    end
    execute_i = '0;
    for (int k = 0; k < 6; k++) chk("lock_order", 64'(seq[k]), 64'(exp_lk[k]));

    // Randomized requesters and memory behaviour.
    repeat (3) @(negedge clk);
    ack_cnt = 0; err_cnt = 0;
    mem_mode = 1; auto_req = 1;
    repeat (1500) @(negedge clk);
    chk("random_acks_seen", 64'(ack_cnt > 100), 64'd1);
    mem_mode = 2;
    repeat (200) @(negedge clk);
    chk("random_timeouts_seen", 64'(err_cnt > 5), 64'd1);
    mem_mode = 1;
    repeat (300) @(negedge clk);
    auto_req = 0; execute_i = '0; lock_i = '0;
    repeat (30) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
